// File: rtl/uart_console_rx.sv
// -----------------------------------------------------------------------------
// uart_console_rx
//
// Serial console receiver. Watches a UART line, decodes 8N1 frames into bytes,
// and buffers them in a first-word-fall-through FIFO. Downstream logic drains
// the FIFO through a valid/ready handshake.
//
// Parameters
//    CLKS_PER_BIT  clk_i cycles per bit time (even, >= 4)
//    FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
// Ports
//    clk_i        in   1   clock
//    rst_ni       in   1   asynchronous reset, active low
//    en_i         in   1   receiver enable; low = line ignored
//    serial_i     in   1   serial line, idle high, asynchronous to clk_i
//    rdata_o      out  8   FIFO head byte (valid while rvalid_o=1)
//    rvalid_o     out  1   FIFO not empty
//    rready_i     in   1   pop head when rvalid_o & rready_i
//    frame_err_o  out  1   one-cycle pulse: stop bit sampled low
//    overflow_o   out  1   sticky: a byte was dropped because FIFO was full
//    clr_i        in   1   clears overflow_o
//    newline_o    out  1   one-cycle pulse when byte 0x0A is pushed
//    level_o      out  LW  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_console_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            en_i,
   input  logic                            serial_i,
   output logic [7:0]                      rdata_o,
   output logic                            rvalid_o,
   input  logic                            rready_i,
   output logic                            frame_err_o,
   output logic                            overflow_o,
   input  logic                            clr_i,
   output logic                            newline_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o
);

   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   // ---------------------------------------------------------------- input path
   logic r_sync1;
   logic r_sync2;
   logic r_s_prev;
   logic w_s;
   logic w_fall;

   // Synchronizer flops reset to the idle (high) level so that reset release
   // never looks like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_s_prev <= 1'b1;
      end else begin
         r_sync1  <= serial_i;
         r_sync2  <= r_sync1;
         r_s_prev <= r_sync2;
      end
   end

   assign w_s    = r_sync2;
   assign w_fall = r_s_prev & ~w_s;

   // ---------------------------------------------------------------- receiver FSM
   state_t          r_state;
   state_t          w_state_next;
   logic [TW-1:0]   r_tick;
   logic [TW-1:0]   w_tick_next;
   logic [2:0]      r_bitcnt;
   logic [2:0]      w_bitcnt_next;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_next;
   logic            w_push_req;
   logic            w_ferr_set;
   logic            w_half_done;
   logic            w_bit_done;

   assign w_half_done = (r_tick == TW'(HALF - 1));
   assign w_bit_done  = (r_tick == TW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_tick   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_state_next;
         r_tick   <= w_tick_next;
         r_bitcnt <= w_bitcnt_next;
         r_shift  <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_tick_next   = r_tick + TW'(1);
      w_bitcnt_next = r_bitcnt;
      w_shift_next  = r_shift;
      w_push_req    = 1'b0;
      w_ferr_set    = 1'b0;

      if (!en_i) begin
         // Disabling abandons any partial frame without reporting an error.
         w_state_next = S_IDLE;
         w_tick_next  = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_tick_next = '0;
               if (w_fall) begin
                  w_state_next = S_START;
               end
            end
            S_START: begin
               // Re-check the start bit at its centre to reject glitches.
               if (w_half_done) begin
                  w_tick_next = '0;
                  if (w_s) begin
                     w_state_next = S_IDLE;
                  end else begin
                     w_state_next  = S_DATA;
                     w_bitcnt_next = '0;
                  end
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  w_tick_next            = '0;
                  w_shift_next[r_bitcnt] = w_s;
                  if (r_bitcnt == 3'd7) begin
                     w_state_next = S_STOP;
                  end else begin
                     w_bitcnt_next = r_bitcnt + 3'd1;
                  end
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  w_tick_next = '0;
                  if (w_s) begin
                     w_push_req   = 1'b1;
                     w_state_next = S_IDLE;
                  end else begin
                     w_ferr_set   = 1'b1;
                     w_state_next = S_BRK;
                  end
               end
            end
            S_BRK: begin
               // A held-low line (break) must return high before the next frame.
               w_tick_next = '0;
               if (w_s) begin
                  w_state_next = S_IDLE;
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_tick_next  = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW-1:0] w_rptr_next;
   logic [LW-1:0] r_count;
   logic [LW-1:0] w_count_next;
   logic [LW-1:0] w_remain;
   logic [7:0]    r_rdata;
   logic [7:0]    w_head;
   logic          r_rvalid;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          r_overflow;
   logic          r_frame_err;
   logic          r_newline;

   always_comb begin
      w_full       = (r_count == LW'(FIFO_DEPTH));
      w_pop        = r_rvalid & rready_i;
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      w_push       = w_push_req & (~w_full | w_pop);
      w_drop       = w_push_req & w_full & ~w_pop;
      w_count_next = r_count + LW'(w_push) - LW'(w_pop);
      w_rptr_next  = r_rptr + AW'(w_pop);
      w_remain     = r_count - LW'(w_pop);
      // When nothing else remains, the byte being pushed becomes the new head;
      // it is not in the array yet, so it is forwarded directly.
      if (w_remain == '0) begin
         w_head = r_shift;
      end else begin
         w_head = r_mem[w_rptr_next];
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= r_shift;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
         r_newline   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         r_rptr   <= w_rptr_next;
         r_count  <= w_count_next;
         r_rvalid <= (w_count_next != '0);
         if (w_count_next != '0) begin
            r_rdata <= w_head;
         end
         // Clear wins over a same-cycle drop.
         if (clr_i) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
         r_frame_err <= w_ferr_set;
         r_newline   <= w_push & (r_shift == 8'h0A);
      end
   end

   assign rdata_o     = r_rdata;
   assign rvalid_o    = r_rvalid;
   assign level_o     = r_count;
   assign overflow_o  = r_overflow;
   assign frame_err_o = r_frame_err;
   assign newline_o   = r_newline;

endmodule
